// File: rtl/mem_pkg.sv
// Shared types for the fetch/data memory arbiter.
package mem_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam int BE_W = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;
  typedef enum logic {OWN_IF, OWN_D} arb_owner_e;

  // Transaction latched at grant; lane selects the 32-bit half for fetches.
  typedef struct packed {
    arb_owner_e        owner;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic              lane;
  } txn_t;

  function automatic logic [ILEN-1:0] fetch_lane(input logic [XLEN-1:0] d, input logic lane);
    return lane ? d[XLEN-1:ILEN] : d[ILEN-1:0];
  endfunction
endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port 64-bit memory between instruction fetch and the LSU.
// Data wins by default; a starvation counter forces a fetch grant after repeated losses.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [XLEN-1:0]   if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [ILEN-1:0]   if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [BE_W-1:0]   d_be_i,
  input  logic [XLEN-1:0]   d_addr_i,
  input  logic [XLEN-1:0]   d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [XLEN-1:0]   d_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [BE_W-1:0]   mem_be_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic [XLEN-1:0]   mem_rdata_i
);
  localparam int LW = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [LW-1:0] LAT_LAST = LW'((MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_e      state, state_nxt;
  txn_t            txn;
  logic [LW-1:0]   lat_cnt;
  logic [SW-1:0]   starve_cnt;
  logic            arb, fetch_pri, if_gnt, d_gnt, sample;
  logic [ILEN-1:0] if_rdata_q;
  logic [XLEN-1:0] d_rdata_q;
  logic [1:0]      unused_addr;

  assign unused_addr = if_addr_i[1:0];

  // Arbitration happens only from IDLE/RESP; reset masks grants in the same cycle.
  always_comb begin
    arb       = (state == IDLE || state == RESP) && !rst;
    fetch_pri = if_req_i && (starve_cnt == STARVE_MAX);
    if_gnt    = arb && if_req_i && (fetch_pri || !d_req_i);
    d_gnt     = arb && d_req_i && !fetch_pri;
  end

  assign sample = (MEM_LATENCY == 0) ? (state == ISSUE)
                                     : (state == WAIT && lat_cnt == LAT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RESP: state_nxt = (if_gnt || d_gnt) ? ISSUE : IDLE;
      ISSUE:      state_nxt = (MEM_LATENCY == 0) ? RESP : WAIT;
      WAIT:       if (lat_cnt == LAT_LAST) state_nxt = RESP;
      default:    state_nxt = IDLE;
    endcase
  end

  // Outputs; memory fields are only driven during the single ISSUE strobe.
  always_comb begin
    if_gnt_o    = if_gnt;
    d_gnt_o     = d_gnt;
    if_rvalid_o = (state == RESP) && (txn.owner == OWN_IF);
    d_rvalid_o  = (state == RESP) && (txn.owner == OWN_D);
    if_rdata_o  = if_rdata_q;
    d_rdata_o   = d_rdata_q;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (state == ISSUE) begin
      mem_req_o   = 1'b1;
      mem_we_o    = txn.we;
      mem_be_o    = txn.be;
      mem_addr_o  = txn.addr;
      mem_wdata_o = txn.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                  lat_cnt <= '0;
    else if (state == ISSUE)  lat_cnt <= '0;
    else if (state == WAIT)   lat_cnt <= lat_cnt + 1'b1;
  end

  // Counts arbitration cycles that fetch lost; ISSUE/WAIT cycles hold the count.
  always_ff @(posedge clk) begin
    if (rst)                          starve_cnt <= '0;
    else if (!if_req_i || if_gnt)     starve_cnt <= '0;
    else if (arb && starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txn <= '0;
    end else if (if_gnt) begin
      txn.owner <= OWN_IF;
      txn.we    <= 1'b0;
      txn.be    <= '1;
      txn.addr  <= {if_addr_i[XLEN-1:3], 3'b000};
      txn.wdata <= '0;
      txn.lane  <= if_addr_i[2];
    end else if (d_gnt) begin
      txn.owner <= OWN_D;
      txn.we    <= d_we_i;
      txn.be    <= d_be_i;
      txn.addr  <= d_addr_i;
      txn.wdata <= d_wdata_i;
      txn.lane  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else if (sample) begin
      if (txn.owner == OWN_IF) if_rdata_q <= fetch_lane(mem_rdata_i, txn.lane);
      else                     d_rdata_q  <= txn.we ? '0 : mem_rdata_i;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: latency-1 arbiter with registered memory model plus a latency-0 instance.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Latency-1 DUT
  logic        if_req, if_gnt, if_rvalid;
  logic [63:0] if_addr;
  logic [31:0] if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [7:0]  d_be;
  logic [63:0] d_addr, d_wdata, d_rdata;
  logic        m1_req, m1_we;
  logic [7:0]  m1_be;
  logic [63:0] m1_addr, m1_wdata, m1_rdata;

  // Latency-0 DUT
  logic        f0_req, f0_gnt, f0_rvalid;
  logic [63:0] f0_addr;
  logic [31:0] f0_rdata;
  logic        z_req, z_we, d0_gnt, d0_rvalid;
  logic [7:0]  z_be;
  logic [63:0] z_addr, z_wdata, d0_rdata;
  logic        m0_req, m0_we;
  logic [7:0]  m0_be;
  logic [63:0] m0_addr, m0_wdata, m0_rdata;

  mem_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) u_dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr),
    .d_wdata_i(d_wdata), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
    .mem_req_o(m1_req), .mem_we_o(m1_we), .mem_be_o(m1_be), .mem_addr_o(m1_addr),
    .mem_wdata_o(m1_wdata), .mem_rdata_i(m1_rdata)
  );

  mem_arbiter #(.MEM_LATENCY(0), .STARVE_LIMIT(4)) u_dut0 (
    .clk(clk), .rst(rst),
    .if_req_i(f0_req), .if_addr_i(f0_addr), .if_gnt_o(f0_gnt),
    .if_rvalid_o(f0_rvalid), .if_rdata_o(f0_rdata),
    .d_req_i(z_req), .d_we_i(z_we), .d_be_i(z_be), .d_addr_i(z_addr),
    .d_wdata_i(z_wdata), .d_gnt_o(d0_gnt), .d_rvalid_o(d0_rvalid), .d_rdata_o(d0_rdata),
    .mem_req_o(m0_req), .mem_we_o(m0_we), .mem_be_o(m0_be), .mem_addr_o(m0_addr),
    .mem_wdata_o(m0_wdata), .mem_rdata_i(m0_rdata)
  );

  // Registered memory: read data valid the cycle after the strobe.
  logic [63:0] mem1 [0:511];
  always @(posedge clk) begin
    if (rst) begin
      mem1[9'h020] <= 64'h11223344_55667788;
      mem1[9'h040] <= 64'h01234567_89ABCDEF;
      mem1[9'h041] <= 64'h5555AAAA_0F0FF0F0;
    end else if (m1_req) begin
      if (m1_we)
        for (int b = 0; b < 8; b++)
          if (m1_be[b]) mem1[m1_addr[11:3]][b*8 +: 8] <= m1_wdata[b*8 +: 8];
      m1_rdata <= mem1[m1_addr[11:3]];
    end
  end

  // Combinational memory for the latency-0 instance.
  logic [63:0] mem0 [0:511];
  always @(posedge clk) if (rst) mem0[9'h000] <= 64'hDEADBEEF_CAFEF00D;
  assign m0_rdata = mem0[m0_addr[11:3]];

  task automatic step;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; if_req = 1'b1; d_req = 1'b1; f0_req = 1'b1;
    repeat (3) step;
    #1;
    total++; if (if_gnt !== 1'b0 || d_gnt !== 1'b0) $display("FAIL rst_gnt got if=%0b d=%0b exp 0", if_gnt, d_gnt); else passed++;
    total++; if (m1_req !== 1'b0 || m1_we !== 1'b0) $display("FAIL rst_memreq got req=%0b we=%0b exp 0", m1_req, m1_we); else passed++;
    total++; if (m1_addr !== 64'h0 || m1_be !== 8'h0 || m1_wdata !== 64'h0) $display("FAIL rst_memfields got addr=%h be=%h wd=%h exp 0", m1_addr, m1_be, m1_wdata); else passed++;
    total++; if (if_rdata !== 32'h0 || d_rdata !== 64'h0) $display("FAIL rst_rdata got if=%h d=%h exp 0", if_rdata, d_rdata); else passed++;
    total++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) $display("FAIL rst_rvalid got if=%0b d=%0b exp 0", if_rvalid, d_rvalid); else passed++;
    total++; if (f0_gnt !== 1'b0 || f0_rdata !== 32'h0) $display("FAIL rst_dut0 got gnt=%0b rdata=%h exp 0", f0_gnt, f0_rdata); else passed++;
    step; rst = 1'b0; if_req = 1'b0; d_req = 1'b0; f0_req = 1'b0;
    step;
  endtask

  task automatic test_fetch;
    step; if_req = 1'b1; if_addr = 64'h104; #1;
    total++; if (if_gnt !== 1'b1 || d_gnt !== 1'b0) $display("FAIL fetch_gnt got if=%0b d=%0b exp 1/0", if_gnt, d_gnt); else passed++;
    step; if_req = 1'b0; #1;
    total++; if (m1_req !== 1'b1 || m1_addr !== 64'h100) $display("FAIL fetch_memreq got req=%0b addr=%h exp 1/100", m1_req, m1_addr); else passed++;
    total++; if (m1_we !== 1'b0 || m1_be !== 8'hFF) $display("FAIL fetch_webe got we=%0b be=%h exp 0/ff", m1_we, m1_be); else passed++;
    step; #1;
    total++; if (m1_req !== 1'b0 || if_rvalid !== 1'b0) $display("FAIL fetch_wait got req=%0b rvalid=%0b exp 0/0", m1_req, if_rvalid); else passed++;
    step; #1;
    total++; if (if_rvalid !== 1'b1 || d_rvalid !== 1'b0) $display("FAIL fetch_rvalid got if=%0b d=%0b exp 1/0", if_rvalid, d_rvalid); else passed++;
    total++; if (if_rdata !== 32'h11223344) $display("FAIL fetch_rdata got %h exp 11223344", if_rdata); else passed++;
    step; #1;
    total++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h11223344) $display("FAIL fetch_hold got rvalid=%0b rdata=%h exp 0/11223344", if_rvalid, if_rdata); else passed++;
  endtask

  task automatic test_write_read;
    step; d_req = 1'b1; d_we = 1'b1; d_be = 8'h0F; d_addr = 64'h200; d_wdata = 64'hAABBCCDD_EEFF0011; #1;
    total++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0) $display("FAIL wr_gnt got d=%0b if=%0b exp 1/0", d_gnt, if_gnt); else passed++;
    step; d_req = 1'b0; #1;
    total++; if (m1_req !== 1'b1 || m1_we !== 1'b1 || m1_be !== 8'h0F) $display("FAIL wr_mem got req=%0b we=%0b be=%h exp 1/1/0f", m1_req, m1_we, m1_be); else passed++;
    total++; if (m1_addr !== 64'h200 || m1_wdata !== 64'hAABBCCDD_EEFF0011) $display("FAIL wr_memdata got addr=%h wd=%h exp 200/aabbccddeeff0011", m1_addr, m1_wdata); else passed++;
    step; #1;
    total++; if (m1_wdata !== 64'h0 || d_rvalid !== 1'b0) $display("FAIL wr_wait got wd=%h rvalid=%0b exp 0/0", m1_wdata, d_rvalid); else passed++;
    step; #1;
    total++; if (d_rvalid !== 1'b1 || d_rdata !== 64'h0) $display("FAIL wr_resp got rvalid=%0b rdata=%h exp 1/0", d_rvalid, d_rdata); else passed++;
    step; d_req = 1'b1; d_we = 1'b0; d_be = 8'hFF; d_addr = 64'h200; #1;
    total++; if (d_gnt !== 1'b1) $display("FAIL rd_gnt got %0b exp 1", d_gnt); else passed++;
    step; d_req = 1'b0;
    step;
    step; #1;
    total++; if (d_rvalid !== 1'b1 || d_rdata !== 64'h01234567_EEFF0011) $display("FAIL rd_after_wr got rvalid=%0b rdata=%h exp 1/01234567eeff0011", d_rvalid, d_rdata); else passed++;
  endtask

  task automatic test_starve;
    byte seq [6];
    int  ng = 0;
    step; if_req = 1'b1; if_addr = 64'h100; d_req = 1'b1; d_we = 1'b0; d_be = 8'hFF; d_addr = 64'h208;
    for (int c = 0; c < 60 && ng < 6; c++) begin
      #1;
      if (if_gnt && d_gnt) begin
        total++; $display("FAIL starve_both_gnt at cycle %0d got both exp one", c);
      end
      if (d_gnt)  begin seq[ng] = "D"; ng++; end
      else if (if_gnt) begin seq[ng] = "F"; ng++; end
      if (ng < 6) step;
    end
    step; if_req = 1'b0; d_req = 1'b0;
    total++; if (ng !== 6) $display("FAIL starve_timeout got %0d grants exp 6", ng); else passed++;
    if (ng == 6) begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (seq[i] !== ((i == 4) ? "F" : "D")) $display("FAIL starve_seq[%0d] got %c exp %c", i, seq[i], (i == 4) ? "F" : "D");
        else passed++;
      end
    end
    repeat (4) step;
  endtask

  task automatic test_back_to_back;
    step; d_req = 1'b1; d_we = 1'b0; d_be = 8'hFF; d_addr = 64'h200; #1;
    total++; if (d_gnt !== 1'b1) $display("FAIL b2b_gnt1 got %0b exp 1", d_gnt); else passed++;
    step; d_addr = 64'h208; #1;
    total++; if (m1_req !== 1'b1 || m1_addr !== 64'h200 || d_gnt !== 1'b0) $display("FAIL b2b_issue1 got req=%0b addr=%h gnt=%0b exp 1/200/0", m1_req, m1_addr, d_gnt); else passed++;
    step; #1;
    total++; if (m1_req !== 1'b0 || d_gnt !== 1'b0) $display("FAIL b2b_wait1 got req=%0b gnt=%0b exp 0/0", m1_req, d_gnt); else passed++;
    step; #1;
    total++; if (d_rvalid !== 1'b1 || d_gnt !== 1'b1) $display("FAIL b2b_resp_gnt got rvalid=%0b gnt=%0b exp 1/1", d_rvalid, d_gnt); else passed++;
    total++; if (d_rdata !== 64'h01234567_EEFF0011) $display("FAIL b2b_rdata1 got %h exp 01234567eeff0011", d_rdata); else passed++;
    step; d_req = 1'b0; #1;
    total++; if (m1_req !== 1'b1 || m1_addr !== 64'h208) $display("FAIL b2b_issue2 got req=%0b addr=%h exp 1/208", m1_req, m1_addr); else passed++;
    step;
    step; #1;
    total++; if (d_rvalid !== 1'b1 || d_rdata !== 64'h5555AAAA_0F0FF0F0) $display("FAIL b2b_rdata2 got rvalid=%0b rdata=%h exp 1/5555aaaa0f0ff0f0", d_rvalid, d_rdata); else passed++;
    step;
  endtask

  task automatic test_reset_mid;
    step; if_req = 1'b1; if_addr = 64'h104; #1;
    total++; if (if_gnt !== 1'b1) $display("FAIL rmid_gnt got %0b exp 1", if_gnt); else passed++;
    step; if_req = 1'b0;
    step; rst = 1'b1;
    step; rst = 1'b0; if_req = 1'b1; if_addr = 64'h104; #1;
    total++; if (if_rvalid !== 1'b0 || m1_req !== 1'b0 || if_rdata !== 32'h0) $display("FAIL rmid_drop got rvalid=%0b req=%0b rdata=%h exp 0/0/0", if_rvalid, m1_req, if_rdata); else passed++;
    total++; if (if_gnt !== 1'b1) $display("FAIL rmid_idle_gnt got %0b exp 1", if_gnt); else passed++;
    step; if_req = 1'b0;
    step;
    step; #1;
    total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h11223344) $display("FAIL rmid_retry got rvalid=%0b rdata=%h exp 1/11223344", if_rvalid, if_rdata); else passed++;
    step;
  endtask

  task automatic test_lat0;
    step; f0_req = 1'b1; f0_addr = 64'h0; #1;
    total++; if (f0_gnt !== 1'b1) $display("FAIL lat0_gnt got %0b exp 1", f0_gnt); else passed++;
    step; f0_req = 1'b0; #1;
    total++; if (m0_req !== 1'b1 || m0_addr !== 64'h0 || f0_rvalid !== 1'b0) $display("FAIL lat0_issue got req=%0b addr=%h rvalid=%0b exp 1/0/0", m0_req, m0_addr, f0_rvalid); else passed++;
    step; #1;
    total++; if (f0_rvalid !== 1'b1 || f0_rdata !== 32'hCAFEF00D) $display("FAIL lat0_lo got rvalid=%0b rdata=%h exp 1/cafef00d", f0_rvalid, f0_rdata); else passed++;
    step; f0_req = 1'b1; f0_addr = 64'h4; #1;
    total++; if (f0_gnt !== 1'b1) $display("FAIL lat0_gnt2 got %0b exp 1", f0_gnt); else passed++;
    step; f0_req = 1'b0;
    step; #1;
    total++; if (f0_rvalid !== 1'b1 || f0_rdata !== 32'hDEADBEEF) $display("FAIL lat0_hi got rvalid=%0b rdata=%h exp 1/deadbeef", f0_rvalid, f0_rdata); else passed++;
    step;
  endtask

  initial begin
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
    f0_req = 0; f0_addr = 0; z_req = 0; z_we = 0; z_be = 0; z_addr = 0; z_wdata = 0;
    m1_rdata = 0;
    test_reset;
    test_fetch;
    test_write_read;
    test_starve;
    test_back_to_back;
    test_reset_mid;
    test_lat0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
